// File: rtl/pipe_pkg.sv
// Shared MIPS32 pipeline types: datapath widths and the packed control bundle.
// An all-zero control bundle is the one and only bubble encoding.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic [3:0] alu_op;
    } ctrl_t;

    localparam int    CTRL_W      = $bits(ctrl_t);
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/operand_sel.sv
// Decode-stage source operand select: r0 guard, then forward value, then register file.
// Latency: combinational. Backpressure: none, pure datapath mux.
// Flow: stateless; the caller decides whether the result is captured.
module operand_sel #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic [REG_W-1:0]  idx,
    input  logic              fwd_en,
    input  logic [DATA_W-1:0] fwd_val,
    input  logic [DATA_W-1:0] rf_val,
    output logic [DATA_W-1:0] opnd
);

    // $0 reads as zero even if a stale producer targeted it.
    always_comb begin
        opnd = rf_val;
        if (idx == '0) begin
            opnd = '0;
        end else if (fwd_en) begin
            opnd = fwd_val;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand select and load-use interlock; ID_EX_STALL_COUNT_EN adds perf_stall_cnt.
// Latency: 1 cycle decode->EX. Backpressure: hold_e freezes EX and raises stall_d; load-use inserts one bubble.
// flush_e outranks hold and load-use: it always loads a bubble and drops stall_d.
module id_ex_stage #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int REG_W  = pipe_pkg::REG_W,
    parameter int CTRL_W = pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_d,
    input  logic              uses_rt_d,
    input  logic [REG_W-1:0]  rs_d,
    input  logic [REG_W-1:0]  rt_d,
    input  logic [REG_W-1:0]  write_reg_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DATA_W-1:0] imm_d,
    input  logic [DATA_W-1:0] rf_a_d,
    input  logic [DATA_W-1:0] rf_b_d,
    input  logic              forward_src_a_enabled,
    input  logic [DATA_W-1:0] forward_src_a,
    input  logic              forward_src_b_enabled,
    input  logic [DATA_W-1:0] forward_src_b,
    input  logic              flush_e,
    input  logic              hold_e,
    output logic              stall_d,
    output logic              valid_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic [DATA_W-1:0] src_a_e,
    output logic [DATA_W-1:0] src_b_e,
    output logic [DATA_W-1:0] imm_e,
    output logic [REG_W-1:0]  rs_e,
    output logic [REG_W-1:0]  rt_e,
    output logic [REG_W-1:0]  write_reg_e
`ifdef ID_EX_STALL_COUNT_EN
    ,
    output logic [31:0]       perf_stall_cnt
`endif
);

    import pipe_pkg::*;

    logic [DATA_W-1:0] opa, opb;
    logic              lu;

    logic              valid_e_q, valid_e_d;
    ctrl_t             ctrl_e_q, ctrl_e_d;
    logic [DATA_W-1:0] src_a_e_q, src_a_e_d;
    logic [DATA_W-1:0] src_b_e_q, src_b_e_d;
    logic [DATA_W-1:0] imm_e_q, imm_e_d;
    logic [REG_W-1:0]  rs_e_q, rs_e_d;
    logic [REG_W-1:0]  rt_e_q, rt_e_d;
    logic [REG_W-1:0]  write_reg_e_q, write_reg_e_d;

    operand_sel #(.DATA_W(DATA_W), .REG_W(REG_W)) u_sel_a (
        .idx(rs_d), .fwd_en(forward_src_a_enabled), .fwd_val(forward_src_a),
        .rf_val(rf_a_d), .opnd(opa)
    );

    operand_sel #(.DATA_W(DATA_W), .REG_W(REG_W)) u_sel_b (
        .idx(rt_d), .fwd_en(forward_src_b_enabled), .fwd_val(forward_src_b),
        .rf_val(rf_b_d), .opnd(opb)
    );

    // A load in EX only forwards its address, so a dependent consumer must wait one cycle.
    assign lu = valid_d & valid_e_q & ctrl_e_q.mem_to_reg & (write_reg_e_q != '0) &
                ((write_reg_e_q == rs_d) | (uses_rt_d & (write_reg_e_q == rt_d)));

    assign stall_d = (lu | hold_e) & ~flush_e;

    always_comb begin
        valid_e_d     = valid_e_q;
        ctrl_e_d      = ctrl_e_q;
        src_a_e_d     = src_a_e_q;
        src_b_e_d     = src_b_e_q;
        imm_e_d       = imm_e_q;
        rs_e_d        = rs_e_q;
        rt_e_d        = rt_e_q;
        write_reg_e_d = write_reg_e_q;
        if (flush_e || (!hold_e && lu)) begin
            valid_e_d     = 1'b0;
            ctrl_e_d      = CTRL_BUBBLE;
            src_a_e_d     = '0;
            src_b_e_d     = '0;
            imm_e_d       = '0;
            rs_e_d        = '0;
            rt_e_d        = '0;
            write_reg_e_d = '0;
        end else if (!hold_e) begin
            valid_e_d     = valid_d;
            ctrl_e_d      = valid_d ? ctrl_t'(ctrl_d) : CTRL_BUBBLE;
            src_a_e_d     = opa;
            src_b_e_d     = opb;
            imm_e_d       = imm_d;
            rs_e_d        = rs_d;
            rt_e_d        = rt_d;
            write_reg_e_d = write_reg_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_e_q     <= 1'b0;
            ctrl_e_q      <= CTRL_BUBBLE;
            src_a_e_q     <= '0;
            src_b_e_q     <= '0;
            imm_e_q       <= '0;
            rs_e_q        <= '0;
            rt_e_q        <= '0;
            write_reg_e_q <= '0;
        end else begin
            valid_e_q     <= valid_e_d;
            ctrl_e_q      <= ctrl_e_d;
            src_a_e_q     <= src_a_e_d;
            src_b_e_q     <= src_b_e_d;
            imm_e_q       <= imm_e_d;
            rs_e_q        <= rs_e_d;
            rt_e_q        <= rt_e_d;
            write_reg_e_q <= write_reg_e_d;
        end
    end

    assign valid_e     = valid_e_q;
    assign ctrl_e      = ctrl_e_q;
    assign src_a_e     = src_a_e_q;
    assign src_b_e     = src_b_e_q;
    assign imm_e       = imm_e_q;
    assign rs_e        = rs_e_q;
    assign rt_e        = rt_e_q;
    assign write_reg_e = write_reg_e_q;

`ifdef ID_EX_STALL_COUNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counts only bubbles actually inserted by the interlock, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (lu && !flush_e && !hold_e && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: stimulus pushes expected EX contents, a monitor pops and compares after each edge.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_d = 1'b0, uses_rt_d = 1'b0;
    logic [4:0]  rs_d = '0, rt_d = '0, write_reg_d = '0;
    logic [9:0]  ctrl_d = '0;
    logic [31:0] imm_d = '0, rf_a_d = '0, rf_b_d = '0;
    logic        forward_src_a_enabled = 1'b0, forward_src_b_enabled = 1'b0;
    logic [31:0] forward_src_a = '0, forward_src_b = '0;
    logic        flush_e = 1'b0, hold_e = 1'b0;
    logic        stall_d, valid_e;
    logic [9:0]  ctrl_e;
    logic [31:0] src_a_e, src_b_e, imm_e;
    logic [4:0]  rs_e, rt_e, write_reg_e;
    logic [31:0] cnt_obs;

    always #5 clk = ~clk;

`ifdef ID_EX_STALL_COUNT_EN
    logic [31:0] perf_stall_cnt;
    assign cnt_obs = perf_stall_cnt;
`else
    assign cnt_obs = '0;
`endif

    id_ex_stage dut (
        .clk(clk), .rst(rst), .valid_d(valid_d), .uses_rt_d(uses_rt_d),
        .rs_d(rs_d), .rt_d(rt_d), .write_reg_d(write_reg_d), .ctrl_d(ctrl_d),
        .imm_d(imm_d), .rf_a_d(rf_a_d), .rf_b_d(rf_b_d),
        .forward_src_a_enabled(forward_src_a_enabled), .forward_src_a(forward_src_a),
        .forward_src_b_enabled(forward_src_b_enabled), .forward_src_b(forward_src_b),
        .flush_e(flush_e), .hold_e(hold_e), .stall_d(stall_d), .valid_e(valid_e),
        .ctrl_e(ctrl_e), .src_a_e(src_a_e), .src_b_e(src_b_e), .imm_e(imm_e),
        .rs_e(rs_e), .rt_e(rt_e), .write_reg_e(write_reg_e)
`ifdef ID_EX_STALL_COUNT_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    typedef struct {
        string       nm;
        logic        v;
        logic [9:0]  c;
        logic [31:0] a, b, imm;
        logic [4:0]  rs, rt, wr;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;

    function automatic exp_t mk(input string nm, input logic v, input logic [9:0] c,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                                input logic [31:0] cnt);
        exp_t e;
        e.nm = nm; e.v = v; e.c = c; e.a = a; e.b = b; e.imm = imm;
        e.rs = rs; e.rt = rt; e.wr = wr;
`ifdef ID_EX_STALL_COUNT_EN
        e.cnt = cnt;
`else
        e.cnt = '0;
`endif
        return e;
    endfunction

    task automatic drv(input logic vd, input logic urt, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] wr, input logic [9:0] c, input logic [31:0] imm,
                       input logic [31:0] ra, input logic [31:0] rb,
                       input logic fa_en, input logic [31:0] fa, input logic fb_en, input logic [31:0] fb,
                       input logic fl, input logic hd);
        valid_d = vd; uses_rt_d = urt; rs_d = rs; rt_d = rt; write_reg_d = wr; ctrl_d = c;
        imm_d = imm; rf_a_d = ra; rf_b_d = rb;
        forward_src_a_enabled = fa_en; forward_src_a = fa;
        forward_src_b_enabled = fb_en; forward_src_b = fb;
        flush_e = fl; hold_e = hd;
    endtask

    // Called just after a falling edge with inputs driven; checks stall_d and queues the post-edge EX state.
    task automatic cyc(input logic exp_stall, input exp_t e);
        #1;
        total++;
        if (stall_d !== exp_stall) begin
            bad++;
            $display("FAIL %s stall_d got=%0b want=%0b", e.nm, stall_d, exp_stall);
        end
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string nm);
        total++;
        if (valid_e !== 1'b0 || ctrl_e !== '0 || src_a_e !== '0 || src_b_e !== '0 || imm_e !== '0 ||
            rs_e !== '0 || rt_e !== '0 || write_reg_e !== '0 || cnt_obs !== '0) begin
            bad++;
            $display("FAIL %s got v=%0b c=%h a=%h b=%h imm=%h rs=%0d rt=%0d wr=%0d cnt=%0d want all zero",
                     nm, valid_e, ctrl_e, src_a_e, src_b_e, imm_e, rs_e, rt_e, write_reg_e, cnt_obs);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                mon_e = q.pop_front();
                total++;
                if (valid_e !== mon_e.v || ctrl_e !== mon_e.c || src_a_e !== mon_e.a ||
                    src_b_e !== mon_e.b || imm_e !== mon_e.imm || rs_e !== mon_e.rs ||
                    rt_e !== mon_e.rt || write_reg_e !== mon_e.wr || cnt_obs !== mon_e.cnt) begin
                    bad++;
                    $display("FAIL %s got v=%0b c=%h a=%h b=%h imm=%h rs=%0d rt=%0d wr=%0d cnt=%0d want v=%0b c=%h a=%h b=%h imm=%h rs=%0d rt=%0d wr=%0d cnt=%0d",
                             mon_e.nm, valid_e, ctrl_e, src_a_e, src_b_e, imm_e, rs_e, rt_e, write_reg_e, cnt_obs,
                             mon_e.v, mon_e.c, mon_e.a, mon_e.b, mon_e.imm, mon_e.rs, mon_e.rt, mon_e.wr, mon_e.cnt);
                end
            end
        end
    end

    initial begin
        #1 rst = 1'b1;
        #2 chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        drv(1,1, 5,6,7, 10'h202, 32'h10, 32'h1, 32'h22, 1,32'hDEADBEEF, 0,32'h0, 0,0);
        cyc(0, mk("fwd_a", 1,10'h202, 32'hDEADBEEF,32'h22,32'h10, 5,6,7, 0));

        drv(1,1, 3,0,9, 10'h202, 32'h0, 32'h33, 32'h99, 0,32'h0, 1,32'h1234, 0,0);
        cyc(0, mk("r0_b", 1,10'h202, 32'h33,32'h0,32'h0, 3,0,9, 0));

        drv(1,1, 0,4,8, 10'h320, 32'h4, 32'h77, 32'h44, 1,32'h5555, 0,32'h0, 0,0);
        cyc(0, mk("r0_a_lw", 1,10'h320, 32'h0,32'h44,32'h4, 0,4,8, 0));

        drv(1,1, 8,9,10, 10'h212, 32'h0, 32'h80, 32'h90, 0,32'h0, 0,32'h0, 0,0);
        cyc(1, mk("lu_rs_bubble", 0,10'h0, 32'h0,32'h0,32'h0, 0,0,0, 1));

        drv(1,1, 8,9,10, 10'h212, 32'h0, 32'h80, 32'h90, 1,32'hABCD0000, 0,32'h0, 0,0);
        cyc(0, mk("lu_retry", 1,10'h212, 32'hABCD0000,32'h90,32'h0, 8,9,10, 1));

        drv(1,1, 1,2,8, 10'h320, 32'h8, 32'h100, 32'h200, 0,32'h0, 0,32'h0, 0,0);
        cyc(0, mk("lw2", 1,10'h320, 32'h100,32'h200,32'h8, 1,2,8, 1));

        drv(1,0, 3,8,11, 10'h220, 32'h5, 32'h30, 32'h80, 0,32'h0, 0,32'h0, 0,0);
        cyc(0, mk("rt_not_src", 1,10'h220, 32'h30,32'h80,32'h5, 3,8,11, 1));

        drv(1,1, 1,2,12, 10'h320, 32'h0, 32'h1, 32'h2, 0,32'h0, 0,32'h0, 0,0);
        cyc(0, mk("lw3", 1,10'h320, 32'h1,32'h2,32'h0, 1,2,12, 1));

        drv(1,1, 12,3,13, 10'h212, 32'h0, 32'h5, 32'h6, 0,32'h0, 0,32'h0, 1,0);
        cyc(0, mk("flush_over_lu", 0,10'h0, 32'h0,32'h0,32'h0, 0,0,0, 1));

        drv(1,1, 1,2,14, 10'h320, 32'h0, 32'h1, 32'h2, 0,32'h0, 0,32'h0, 0,0);
        cyc(0, mk("lw4", 1,10'h320, 32'h1,32'h2,32'h0, 1,2,14, 1));

        drv(1,1, 3,14,15, 10'h212, 32'h0, 32'h30, 32'h140, 0,32'h0, 0,32'h0, 0,0);
        cyc(1, mk("lu_rt_bubble", 0,10'h0, 32'h0,32'h0,32'h0, 0,0,0, 2));

        drv(0,1, 3,14,15, 10'h212, 32'h0, 32'h30, 32'h140, 0,32'h0, 0,32'h0, 0,0);
        cyc(0, mk("invalid_masks_ctrl", 0,10'h0, 32'h30,32'h140,32'h0, 3,14,15, 2));

        drv(1,1, 1,2,16, 10'h320, 32'h40, 32'h11, 32'h22, 0,32'h0, 0,32'h0, 0,0);
        cyc(0, mk("lw5", 1,10'h320, 32'h11,32'h22,32'h40, 1,2,16, 2));

        for (int i = 0; i < 3; i++) begin
            drv(1,1, 16,2,17, 10'h212, 32'h0, 32'hA0 + i, 32'hB0 + i, 0,32'h0, 0,32'h0, 0,1);
            cyc(1, mk("hold", 1,10'h320, 32'h11,32'h22,32'h40, 1,2,16, 2));
        end

        rst = 1'b1;
        #1 chk_zero("rst_mid_hold");
        @(posedge clk);
        #1 chk_zero("rst_held_edge");
        @(negedge clk);
        rst = 1'b0;

        drv(1,1, 2,3,4, 10'h202, 32'h0, 32'h7, 32'h8, 0,32'h0, 0,32'h0, 0,0);
        cyc(0, mk("after_rst", 1,10'h202, 32'h7,32'h8,32'h0, 2,3,4, 0));

        drv(1,1, 4,5,6, 10'h202, 32'h0, 32'h1, 32'h2, 0,32'h0, 0,32'h0, 1,1);
        cyc(0, mk("flush_over_hold", 0,10'h0, 32'h0,32'h0,32'h0, 0,0,0, 0));

        drv(0,0, 0,0,0, 10'h0, 32'h0, 32'h0, 32'h0, 0,32'h0, 0,32'h0, 0,0);
        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
